// File: rtl/freq_gauge_sched_if.sv
// ---------------------------------------------------------------------------
// freq_gauge_sched_if
// Avalon-MM register bus used by freq_gauge_sched.
//
// Signals:
//   mm_address   [3:0]  word address
//   mm_read             read strobe, one cycle per access
//   mm_write            write strobe, one cycle per access
//   mm_writedata [31:0] write data, qualified by mm_write
//   mm_readdata  [31:0] read data
//
// Handshake: there is no waitrequest, so every strobe is accepted in the
// cycle it is high. A write is sampled on the rising edge that ends the
// strobe cycle. Read data for a strobe sampled on edge N is valid after
// edge N and holds until the next accepted read.
// ---------------------------------------------------------------------------
interface freq_gauge_sched_if;
    logic [3:0]  mm_address;
    logic        mm_read;
    logic        mm_write;
    logic [31:0] mm_writedata;
    logic [31:0] mm_readdata;

    modport master (
        output mm_address, mm_read, mm_write, mm_writedata,
        input  mm_readdata
    );

    modport slave (
        input  mm_address, mm_read, mm_write, mm_writedata,
        output mm_readdata
    );
endinterface

// File: rtl/freq_gauge_sched.sv
// ---------------------------------------------------------------------------
// freq_gauge_sched
// Time-shares one external freq_gauge across several probe clocks. For each
// enabled channel it selects the probe through probe_sel, holds the gauge in
// reset while the mux settles, lets it measure, then captures its reading
// into a per-channel RESULT register.
//
// Ports:
//   clk          reference clock (also the gauge reference clock)
//   reset_n      asynchronous active-low reset
//   mm           register bus (slave modport)
//   gauge_data   gauge reading in Hz
//   probe_sel    external probe mux select
//   gauge_reset  gauge reset, active high
//   dbg_state    current FSM state (IDLE=0 SETTLE=1 MEASURE=2 CAPTURE=3 NEXT=4)
//
// Registers: 0 CTRL {mask[8+:Channels], clear_valid(w1, reads 0), enable}
//            1 STATUS {valid[8+:Channels], busy[4], channel[2:0]}
//            2+i RESULT[i]; everything else reads 0.
// ---------------------------------------------------------------------------
module freq_gauge_sched #(
    parameter  int Channels      = 4,
    parameter  int SettleCycles  = 16,
    parameter  int MeasureCycles = 120000,
    localparam int SelW          = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    freq_gauge_sched_if.slave        mm,
    input  logic [31:0]              gauge_data,
    output logic [SelW-1:0]          probe_sel,
    output logic                     gauge_reset,
    output logic [2:0]               dbg_state
);

    localparam int CntMax = (SettleCycles > MeasureCycles) ? SettleCycles : MeasureCycles;
    localparam int CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_NEXT    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SelW-1:0]       sel_q, sel_d;
    logic                  enable_q, enable_d;
    logic [Channels-1:0]   mask_q, mask_d;
    logic [Channels-1:0]   valid_q, valid_d;
    logic [31:0]           result_q [Channels];
    logic [31:0]           result_d [Channels];
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            sync_q;

    logic                  run_ok;
    logic                  run;
    logic                  capture;
    logic                  wr_ctrl;
    logic [SelW-1:0]       lowest_sel;
    logic [SelW-1:0]       next_sel;
    logic [SelW-1:0]       cand;

    // Reset release is re-timed to clk; the FSM only starts once both
    // synchroniser stages have seen reset_n high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], 1'b1};
    end
    assign run_ok = sync_q[1];

    assign run     = enable_q && (mask_q != '0);
    assign wr_ctrl = mm.mm_write && (mm.mm_address == 4'd0);

    // Channel search: lowest set mask bit, and the first set bit strictly
    // after the current channel (wrapping; the current channel itself is the
    // last candidate, so a single-bit mask reselects it).
    always_comb begin
        lowest_sel = '0;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (mask_q[i]) lowest_sel = SelW'(i);
        end
        next_sel = sel_q;
        cand     = '0;
        for (int i = Channels; i >= 1; i--) begin
            cand = SelW'((int'(sel_q) + i) % Channels);
            if (mask_q[cand]) next_sel = cand;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run && run_ok) begin
                    state_d = ST_SETTLE;
                    sel_d   = lowest_sel;
                end
            end
            ST_SETTLE: begin
                if (!run)                                   state_d = ST_IDLE;
                else if (!mask_q[sel_q])                    state_d = ST_NEXT;
                else if (cnt_q == CntW'(SettleCycles - 1))  state_d = ST_MEASURE;
                else                                        cnt_d   = cnt_q + CntW'(1);
            end
            ST_MEASURE: begin
                if (!run)                                   state_d = ST_IDLE;
                else if (!mask_q[sel_q])                    state_d = ST_NEXT;
                else if (cnt_q == CntW'(MeasureCycles - 1)) state_d = ST_CAPTURE;
                else                                        cnt_d   = cnt_q + CntW'(1);
            end
            ST_CAPTURE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    capture = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    sel_d   = next_sel;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Every state entry starts its count from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    // Register file update. clear_valid acts on the same edge as a capture
    // but is applied first, so the captured channel keeps its valid bit.
    always_comb begin
        enable_d = enable_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        for (int i = 0; i < Channels; i++) result_d[i] = result_q[i];
        if (wr_ctrl) begin
            enable_d = mm.mm_writedata[0];
            mask_d   = mm.mm_writedata[8 +: Channels];
            if (mm.mm_writedata[1]) valid_d = '0;
        end
        if (capture) begin
            valid_d[sel_q]  = 1'b1;
            result_d[sel_q] = gauge_data;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (mm.mm_read) begin
            rdata_d = '0;
            if (mm.mm_address == 4'd0) begin
                rdata_d[0]             = enable_q;
                rdata_d[8 +: Channels] = mask_q;
            end else if (mm.mm_address == 4'd1) begin
                rdata_d[2:0]           = 3'(sel_q);
                rdata_d[4]             = (state_q != ST_IDLE);
                rdata_d[8 +: Channels] = valid_q;
            end else begin
                for (int i = 0; i < Channels; i++) begin
                    if (mm.mm_address == 4'(i + 2)) rdata_d = result_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            enable_q <= 1'b0;
            mask_q   <= '0;
            valid_q  <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < Channels; i++) result_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < Channels; i++) result_q[i] <= result_d[i];
        end
    end

    assign probe_sel      = sel_q;
    assign gauge_reset    = !((state_q == ST_MEASURE) || (state_q == ST_CAPTURE));
    assign dbg_state      = state_q;
    assign mm.mm_readdata = rdata_q;

endmodule

// File: doc/freq_gauge_sched.md
FREQ_GAUGE_SCHED -- requirements
Module: freq_gauge_sched

Interface
REQ-001 Parameter Channels, default 4: number of probe clocks time-shared on one freq_gauge; legal range 1..8.
REQ-002 Parameter SettleCycles, default 16: clk cycles the gauge is held in reset after a channel switch; minimum 1.
REQ-003 Parameter MeasureCycles, default 120000: clk cycles from gauge reset release to capture; must cover one full gauge measurement; minimum 1.
REQ-004 clk  in  1: the reference clock that also drives freq_gauge ref_clk; sole clock of this block.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 probe_sel  out  $clog2(Channels) (min 1): select for the external probe clock mux.
REQ-007 gauge_reset  out  1: drives freq_gauge reset; active high.
REQ-008 gauge_data  in  32: freq_gauge mm_readdata, in Hz.
REQ-009 mm_address  in  4: word address.
REQ-010 mm_read  in  1 / mm_write  in  1: Avalon-MM strobes, no waitrequest.
REQ-011 mm_writedata  in  32 / mm_readdata  out  32: write and read data.

Function
REQ-012 Register map: 0 CTRL (rw); 1 STATUS (ro); 2+i RESULT[i] (ro) for i<Channels; any other address reads 0.
REQ-013 CTRL fields: bit0 enable; bit1 clear_valid (self-clearing, reads 0); bits[8+Channels-1:8] channel mask.
REQ-014 STATUS fields: bits[2:0] current channel; bit4 busy (state != IDLE); bits[8+Channels-1:8] per-channel valid.
REQ-015 mm_readdata is registered with fixed 1-cycle read latency; it holds its last value when mm_read is low.
REQ-016 Writes to STATUS, RESULT or unmapped addresses are ignored.
REQ-017 States: IDLE, SETTLE, MEASURE, CAPTURE, NEXT.
REQ-018 IDLE -> SETTLE when enable=1 and mask!=0; probe_sel is loaded with the lowest set mask bit.
REQ-019 SETTLE: gauge_reset=1; the counter counts SettleCycles cycles, then the FSM goes to MEASURE.
REQ-020 MEASURE: gauge_reset=0; the counter counts MeasureCycles cycles, then the FSM goes to CAPTURE.
REQ-021 CAPTURE (1 cycle): RESULT[probe_sel] <= gauge_data; valid[probe_sel] <= 1; the FSM goes to NEXT.
REQ-022 NEXT (1 cycle): probe_sel advances round-robin to the next set mask bit strictly after the current channel, wrapping modulo Channels; if only one bit is set, the same channel is reselected; the FSM goes to SETTLE.
REQ-023 gauge_reset is 1 in IDLE, SETTLE and NEXT, and 0 otherwise.
REQ-024 If enable=0 or mask=0 in any non-IDLE state, the FSM goes to IDLE on the next cycle; no capture occurs and RESULT/valid are untouched.
REQ-025 If the mask bit of the current channel is cleared during SETTLE or MEASURE, the measurement is aborted and the FSM goes to NEXT; no capture occurs.
REQ-026 A CTRL write takes effect on the cycle after the write strobe.
REQ-027 clear_valid zeroes all valid bits; if a CAPTURE happens in the same cycle, the clear applies first, so the captured channel's valid bit ends at 1.
REQ-028 The counter width is $clog2(max(SettleCycles,MeasureCycles)+1); the counter reloads to 0 on every state entry.
REQ-029 Result latency per channel is SettleCycles+MeasureCycles+2 cycles; a full sweep takes N times that, where N is the number of mask bits set.

Reset
REQ-030 While reset_n=0: state=IDLE, CTRL=0, all RESULT=0, all valid=0, probe_sel=0, gauge_reset=1, counter=0, mm_readdata=0.
REQ-031 Reset assertion mid-measurement takes effect immediately and asynchronously; deassertion is synchronised to clk with a 2-flop synchroniser before the FSM leaves IDLE.

Verification (SettleCycles=4, MeasureCycles=20, Channels=4, gauge_data driven by the bench)
REQ-032 Write CTRL=0x0000_0F01 with gauge_data=1000+probe_sel -> RESULT[0..3] reads 1000,1001,1002,1003; STATUS valid=0xF; captures are 26 cycles apart.
REQ-033 Write mask=0x0A (0x0A01) -> probe_sel sequence 1,3,1,3; RESULT[0] and RESULT[2] stay 0.
REQ-034 Clear enable during MEASURE of channel 2 -> IDLE on the next cycle, gauge_reset=1, valid[2] unchanged, busy=0.
REQ-035 Write clear_valid in the CAPTURE cycle of channel 1 -> STATUS valid=0x02.
REQ-036 Assert reset_n=0 mid-MEASURE -> all outputs at reset values within the same cycle; after deassertion plus 2 cycles with enable=1, SETTLE restarts at channel 0.
REQ-037 Read unmapped address 0xF -> 0x0000_0000 one cycle after mm_read.
